// File: rtl/gb_frame_sequencer_if.sv
// Bundles the APU power/DIV inputs with the strobe and step outputs
// of the frame sequencer.
interface gb_frame_sequencer_if;
    logic       apu_en;
    logic       div_bit;
    logic       clk_length_ctr;
    logic       clk_sweep;
    logic       clk_envelope;
    logic [2:0] step;
    logic       len_half;

    modport master (
        output apu_en,
        output div_bit,
        input  clk_length_ctr,
        input  clk_sweep,
        input  clk_envelope,
        input  step,
        input  len_half
    );

    modport slave (
        input  apu_en,
        input  div_bit,
        output clk_length_ctr,
        output clk_sweep,
        output clk_envelope,
        output step,
        output len_half
    );
endinterface

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: turns a 512 Hz tick into the length (256 Hz),
// sweep (128 Hz) and envelope (64 Hz) one-cycle strobes. The tick
// comes from a DIV bit falling edge (PRESCALE=0) or from an internal
// prescaler (PRESCALE>0).
module gb_frame_sequencer #(
    parameter int unsigned PRESCALE = 0,
    parameter int unsigned CTR_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    gb_frame_sequencer_if.slave bus
);

    localparam int unsigned   LAST_I = (PRESCALE == 0) ? 0 : PRESCALE - 1;
    localparam logic [CTR_W-1:0] W_LAST = CTR_W'(LAST_I);

    logic             r_div_q;
    logic [CTR_W-1:0] r_count;
    logic [2:0]       r_step;
    logic             r_len;
    logic             r_sweep;
    logic             r_env;
    logic             w_count_last;
    logic             w_tick;

    // DIV bit history; tracks even while powered off so enabling never
    // sees a stale high and fabricates a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_q <= 1'b0;
        end else begin
            r_div_q <= bus.div_bit;
        end
    end

    // Prescaler count; parked at zero when unused or powered off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (PRESCALE == 0 || !bus.apu_en || w_count_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CTR_W'(1);
        end
    end

    // Tick source selection.
    always_comb begin
        w_count_last = (r_count == W_LAST);
        w_tick       = 1'b0;
        if (PRESCALE == 0) begin
            w_tick = r_div_q & ~bus.div_bit;
        end else begin
            w_tick = w_count_last;
        end
    end

    // Step advance and strobe decode from the pre-increment step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step  <= '0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end else if (!bus.apu_en) begin
            r_step  <= '0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end else if (w_tick) begin
            r_len   <= ~r_step[0];
            r_sweep <= (r_step[1:0] == 2'b10);
            r_env   <= (r_step == 3'd7);
            r_step  <= r_step + 3'd1;
        end else begin
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end
    end

    assign bus.clk_length_ctr = r_len;
    assign bus.clk_sweep      = r_sweep;
    assign bus.clk_envelope   = r_env;
    assign bus.step           = r_step;
    assign bus.len_half       = r_step[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed bench for gb_frame_sequencer: DIV-edge build and PRESCALE=4 build.
module tb_gb_frame_sequencer;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    logic [7:0] len_t;
    logic [7:0] swp_t;
    logic [7:0] env_t;

    gb_frame_sequencer_if ife ();
    gb_frame_sequencer_if ifp ();

    gb_frame_sequencer #(.PRESCALE(0), .CTR_W(16)) dut_e (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ife)
    );

    gb_frame_sequencer #(.PRESCALE(4), .CTR_W(4)) dut_p (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DIV falling edge on the edge-mode DUT; checks the strobe cycle
    // and the following cycle. Leaves div_bit high and sampled.
    task automatic pulse_e(input string tag, input logic el, input logic es,
                           input logic ee, input logic [2:0] est);
        @(negedge clk);
        ife.div_bit = 1'b0;
        @(negedge clk);
        chk({tag, "_len"},   8'(ife.clk_length_ctr), 8'(el));
        chk({tag, "_swp"},   8'(ife.clk_sweep),      8'(es));
        chk({tag, "_env"},   8'(ife.clk_envelope),   8'(ee));
        chk({tag, "_step"},  8'(ife.step),           8'(est));
        chk({tag, "_half"},  8'(ife.len_half),       8'(est[0]));
        ife.div_bit = 1'b1;
        @(negedge clk);
        chk({tag, "_off"}, 8'({ife.clk_length_ctr, ife.clk_sweep, ife.clk_envelope}), 8'd0);
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        len_t = 8'h55;  // steps 0,2,4,6
        swp_t = 8'h44;  // steps 2,6
        env_t = 8'h80;  // step 7

        // 1: reset with div_bit toggling
        rst_n       = 1'b0;
        ife.apu_en  = 1'b1;
        ife.div_bit = 1'b0;
        ifp.apu_en  = 1'b0;
        ifp.div_bit = 1'b0;
        #1;
        chk("rst_step", 8'(ife.step), 8'd0);
        chk("rst_half", 8'(ife.len_half), 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ife.div_bit = ~ife.div_bit;
            chk("rst_strobes", 8'({ife.clk_length_ctr, ife.clk_sweep, ife.clk_envelope}), 8'd0);
        end
        rst_n = 1'b1;  // div_bit is 1 here
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_strobes", 8'({ife.clk_length_ctr, ife.clk_sweep, ife.clk_envelope}), 8'd0);
            chk("post_rst_step", 8'(ife.step), 8'd0);
        end

        // 2: eight ticks, 20 cycles apart
        for (int k = 0; k < 8; k++) begin
            pulse_e("seq", len_t[k], swp_t[k], env_t[k], 3'((k + 1) % 8));
            repeat (17) @(negedge clk);
        end
        chk("seq_wrap_step", 8'(ife.step), 8'd0);

        // 3: advance to step 5, power off for 4 cycles, power on
        pulse_e("adv0", 1'b1, 1'b0, 1'b0, 3'd1);
        pulse_e("adv1", 1'b0, 1'b0, 1'b0, 3'd2);
        pulse_e("adv2", 1'b1, 1'b1, 1'b0, 3'd3);
        pulse_e("adv3", 1'b0, 1'b0, 1'b0, 3'd4);
        pulse_e("adv4", 1'b1, 1'b0, 1'b0, 3'd5);
        ife.apu_en = 1'b0;
        @(negedge clk);
        chk("off_step", 8'(ife.step), 8'd0);
        chk("off_half", 8'(ife.len_half), 8'd0);
        ife.div_bit = 1'b0;  // tick while off must be ignored
        @(negedge clk);
        chk("off_tick_len", 8'(ife.clk_length_ctr), 8'd0);
        chk("off_tick_step", 8'(ife.step), 8'd0);
        ife.div_bit = 1'b1;
        repeat (2) @(negedge clk);
        ife.apu_en = 1'b1;
        @(negedge clk);
        chk("on_step", 8'(ife.step), 8'd0);
        chk("on_strobes", 8'({ife.clk_length_ctr, ife.clk_sweep, ife.clk_envelope}), 8'd0);
        pulse_e("on_tick", 1'b1, 1'b0, 1'b0, 3'd1);

        // 4: DIV write while enabled produces exactly one tick
        ife.apu_en = 1'b0;
        repeat (3) @(negedge clk);
        ife.apu_en = 1'b1;
        @(negedge clk);
        ife.div_bit = 1'b0;
        @(negedge clk);
        chk("divw_len", 8'(ife.clk_length_ctr), 8'd1);
        chk("divw_step", 8'(ife.step), 8'd1);
        chk("divw_half", 8'(ife.len_half), 8'd1);
        @(negedge clk);
        chk("divw_len_clr", 8'(ife.clk_length_ctr), 8'd0);
        repeat (3) @(negedge clk);
        chk("divw_once_step", 8'(ife.step), 8'd1);
        chk("divw_once_len", 8'(ife.clk_length_ctr), 8'd0);

        // 4b: power-off coincident with tick
        ife.div_bit = 1'b1;
        @(negedge clk);
        ife.apu_en  = 1'b0;
        ife.div_bit = 1'b0;
        @(negedge clk);
        chk("offtick_len", 8'(ife.clk_length_ctr), 8'd0);
        chk("offtick_step", 8'(ife.step), 8'd0);

        // 4c: power-on coincident with tick
        ife.div_bit = 1'b1;
        @(negedge clk);
        ife.apu_en  = 1'b1;
        ife.div_bit = 1'b0;
        @(negedge clk);
        chk("ontick_len", 8'(ife.clk_length_ctr), 8'd1);
        chk("ontick_step", 8'(ife.step), 8'd1);

        // 5: PRESCALE=4 build, div_bit ignored
        @(negedge clk);
        ifp.apu_en = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            logic tk;
            int   k;
            @(negedge clk);
            ifp.div_bit = ~ifp.div_bit;
            tk = (n % 4 == 0);
            k  = tk ? ((n / 4) - 1) % 8 : 0;
            chk("pre_len", 8'(ifp.clk_length_ctr), 8'(tk & len_t[k]));
            chk("pre_swp", 8'(ifp.clk_sweep),      8'(tk & swp_t[k]));
            chk("pre_env", 8'(ifp.clk_envelope),   8'(tk & env_t[k]));
            if (n == 32) chk("pre_env_step", 8'(ifp.step), 8'd0);
        end
        // length strobe is high here; reset must clear it without a clock
        rst_n = 1'b0;
        #1;
        chk("async_rst_len", 8'(ifp.clk_length_ctr), 8'd0);
        chk("async_rst_step", 8'(ifp.step), 8'd0);
        #4;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gb_frame_sequencer.md
Name: gb_frame_sequencer

Overview:
- Generates the 512 Hz-derived timing strobes for the APU channels: length clock (256 Hz), sweep clock (128 Hz) and envelope clock (64 Hz).
- Sits directly upstream of the per-channel length, sweep and envelope units; its clk_length_ctr output drives their length-clock input.
- The tick source is either a falling edge on a DIV timer bit or an internal prescaler, selected by parameter.
- Step state is exported so channels can implement the length "extra clock" quirk.

Parameters:
- PRESCALE, default 0: 0 selects the external div_bit falling edge as the tick source. N>0 selects an internal tick every N clk cycles and ignores div_bit.
- CTR_W, default 16: prescaler counter width. The requirement is PRESCALE <= 2^CTR_W. It is unused when PRESCALE=0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- apu_en  in  1  APU master power (NR52 bit 7); 0 holds the sequencer idle
- div_bit  in  1  DIV bit 4 (normal speed) or bit 5 (double speed); a 1->0 transition is one tick
- clk_length_ctr  out  1  one-cycle length strobe
- clk_sweep  out  1  one-cycle sweep strobe
- clk_envelope  out  1  one-cycle envelope strobe
- step  out  3  current step, i.e. the step the next tick will execute
- len_half  out  1  equals step[0]; 1 means the next tick does not clock length

Behaviour:
- Reset (reset=0, asynchronous):
  - step=0, all strobes=0, len_half=0.
  - Edge register div_q=0 and prescaler count=0.
  - Reset release mid-operation restarts from step 0 with no pending tick.
- Edge detect (PRESCALE=0):
  - div_q samples div_bit every cycle, including while apu_en=0.
  - tick = div_q & ~div_bit.
  - A CPU write to DIV that drops div_bit from 1 to 0 therefore produces a tick. This is intended hardware behaviour.
- Prescaler (PRESCALE>0):
  - The count increments each cycle. When count==PRESCALE-1, tick=1 and count wraps to 0.
  - The count is held at 0 while apu_en=0.
- Tick response, on the clk edge where tick=1 and apu_en=1 (registered, latency 1):
  - Strobes are asserted for exactly the next cycle, decoded from the pre-increment step:
    - clk_length_ctr = step in {0,2,4,6}
    - clk_sweep = step in {2,6}
    - clk_envelope = step == 7
  - Step update: step <= step+1 modulo 8, so 7 wraps to 0.
- Strobe width: all strobes deassert on the following edge unless another tick occurs. Back-to-back ticks are possible only with PRESCALE=1, which yields consecutive pulses.
- Power-off (apu_en=0):
  - step forced to 0 and all strobes forced to 0 on the next edge.
  - Ticks are ignored.
- Simultaneous events:
  - apu_en=0 together with tick: no strobe, step=0.
  - apu_en rising on the same cycle as tick: the tick is honoured, so step 0 fires clk_length_ctr.
  - Because div_q keeps tracking while powered off, enabling never creates a spurious tick.
- Full pattern per 8 ticks:
  - 4 length strobes, 2 sweep strobes, 1 envelope strobe.
  - Ticks at steps 1, 3 and 5 produce no strobe.

Test Plan:
1. Reset low for 3 cycles with div_bit toggling, then release -> all strobes 0, step=0, no strobe until the first 1->0 of div_bit after release.
2. apu_en=1; drive 8 falling edges of div_bit spaced 20 cycles apart -> clk_length_ctr pulses after ticks 1,3,5,7; clk_sweep after ticks 3,7; clk_envelope after tick 8. Each pulse is 1 cycle wide, 1 cycle after the edge. step reads back 0 after the 8th tick.
3. Advance to step=5, drop apu_en for 4 cycles, then raise it -> step=0, len_half=0; the next tick pulses only clk_length_ctr.
4. Hold div_bit=1 with apu_en=0, raise apu_en, then force div_bit to 0 as a DIV write -> exactly one tick: clk_length_ctr=1 for 1 cycle, step=1, len_half=1.
5. PRESCALE=4 build with apu_en=1 -> ticks every 4 cycles; clk_envelope first pulses 32 cycles after enable. Reset asserted mid-pulse clears the strobe immediately (asynchronously).
